// File: rtl/pid_pkg.sv
// Shared types and width helpers for the
// multi-channel PID core.
package pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_PROP,
    S_INTG,
    S_DERV,
    S_OUT
  } state_e;

  // ref - meas without wrap
  function automatic int err_w(int dw);
    return dw + 1;
  endfunction

  // e - prev_e without wrap
  function automatic int dif_w(int dw);
    return dw + 2;
  endfunction

  // widest second multiplier operand
  function automatic int mop_w(int dw, int iw);
    return (iw > dw + 2) ? iw : dw + 2;
  endfunction

  // three summed products never overflow
  function automatic int acc_w(
    int cw, int dw, int iw
  );
    return cw + mop_w(dw, iw) + 3;
  endfunction

  function automatic int ch_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pid_sat.sv
// Output stage: drop gain fraction bits
// and clip to the signed output range.
module pid_sat #(
  parameter int AW   = 43,
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic signed [AW-1:0] acc_i,
  output logic signed [DW-1:0] val_o,
  output logic                 hi_o,
  output logic                 lo_o
);

  localparam logic signed [AW-1:0] VMAX =
    AW'({1'b0, {(DW-1){1'b1}}});
  localparam logic signed [AW-1:0] VMIN =
    AW'($signed({1'b1, {(DW-1){1'b0}}}));

  logic signed [AW-1:0] sh;

  // floor shift, then clip and flag
  always_comb begin
    sh    = acc_i >>> FRAC;
    hi_o  = sh > VMAX;
    lo_o  = sh < VMIN;
    val_o = sh[DW-1:0];
    if (hi_o) val_o = VMAX[DW-1:0];
    if (lo_o) val_o = VMIN[DW-1:0];
  end

endmodule

// File: rtl/pid_mc_core.sv
// Time-shared multi-channel PID core with
// per-channel integrator and previous error.
module pid_mc_core
  import pid_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 8,
  parameter int NCH  = 4,
  parameter int IW   = DW + 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ch_w(NCH)-1:0]     in_ch,
  input  logic signed [DW-1:0]     ref_in,
  input  logic signed [DW-1:0]     meas,
  input  logic signed [CW-1:0]     kp,
  input  logic signed [CW-1:0]     ki,
  input  logic signed [CW-1:0]     kd,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ch_w(NCH)-1:0]     out_ch,
  output logic signed [DW-1:0]     out_val,
  output logic                     out_sat
);

  localparam int EW  = err_w(DW);
  localparam int DFW = dif_w(DW);
  localparam int BW  = mop_w(DW, IW);
  localparam int AW  = acc_w(CW, DW, IW);
  localparam int PW  = CW + BW;
  localparam int SW  = BW + 1;
  localparam int CHW = ch_w(NCH);

  localparam logic signed [IW-1:0] IMAX =
    {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] IMIN =
    {1'b1, {(IW-1){1'b0}}};

  state_e state_q, state_d;

  logic [CHW-1:0]        ch_q, ch_d;
  logic signed [DW-1:0]  ref_q, ref_d;
  logic signed [DW-1:0]  meas_q, meas_d;
  logic signed [CW-1:0]  kp_q, kp_d;
  logic signed [CW-1:0]  ki_q, ki_d;
  logic signed [CW-1:0]  kd_q, kd_d;
  logic                  clr_q, clr_d;
  logic signed [EW-1:0]  e_q, e_d;
  logic signed [EW-1:0]  pe_q, pe_d;
  logic signed [IW-1:0]  iold_q, iold_d;
  logic signed [IW-1:0]  icand_q, icand_d;
  logic signed [AW-1:0]  acc_q, acc_d;

  logic                  out_valid_q;
  logic                  out_valid_d;
  logic                  out_sat_q, out_sat_d;
  logic [CHW-1:0]        out_ch_q, out_ch_d;
  logic signed [DW-1:0]  out_val_q, out_val_d;

  logic signed [IW-1:0]  integ_q [NCH];
  logic signed [IW-1:0]  integ_d [NCH];
  logic signed [EW-1:0]  prev_q  [NCH];
  logic signed [EW-1:0]  prev_d  [NCH];

  logic signed [SW-1:0]  isum;
  logic signed [IW-1:0]  icand_c;
  logic signed [DFW-1:0] diff_c;
  logic signed [CW-1:0]  mul_a;
  logic signed [BW-1:0]  mul_b;
  logic signed [PW-1:0]  prod;
  logic signed [DW-1:0]  sat_val;
  logic                  sat_hi, sat_lo;
  logic                  take, wind;

  assign take = out_valid_q && out_ready;

  pid_sat #(
    .AW  (AW),
    .DW  (DW),
    .FRAC(FRAC)
  ) u_sat (
    .acc_i(acc_q),
    .val_o(sat_val),
    .hi_o (sat_hi),
    .lo_o (sat_lo)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // one state per clock, OUT waits for take
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = S_ERR;
      S_ERR:  state_d = S_PROP;
      S_PROP: state_d = S_INTG;
      S_INTG: state_d = S_DERV;
      S_DERV: state_d = S_OUT;
      S_OUT:  if (take) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // handshake outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = out_valid_q;
    out_ch    = out_ch_q;
    out_val   = out_val_q;
    out_sat   = out_sat_q;
  end

  // integrator candidate and derivative diff
  always_comb begin
    isum    = SW'(iold_q) + SW'(e_q);
    icand_c = isum[IW-1:0];
    if (isum > SW'(IMAX)) icand_c = IMAX;
    if (isum < SW'(IMIN)) icand_c = IMIN;
    diff_c  = DFW'(e_q) - DFW'(pe_q);
  end

  // the single shared multiplier
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      S_PROP: begin
        mul_a = kp_q;
        mul_b = BW'(e_q);
      end
      S_INTG: begin
        mul_a = ki_q;
        mul_b = BW'(icand_c);
      end
      S_DERV: begin
        mul_a = kd_q;
        mul_b = BW'(diff_c);
      end
      default: ;
    endcase
    prod = PW'(mul_a) * PW'(mul_b);
  end

  // hold integ if it would push deeper into the clip
  always_comb begin
    wind = (sat_hi && (icand_q > iold_q)) ||
           (sat_lo && (icand_q < iold_q));
  end

  // datapath sequencing and writeback
  always_comb begin
    ch_d        = ch_q;
    ref_d       = ref_q;
    meas_d      = meas_q;
    kp_d        = kp_q;
    ki_d        = ki_q;
    kd_d        = kd_q;
    clr_d       = clr_q;
    e_d         = e_q;
    pe_d        = pe_q;
    iold_d      = iold_q;
    icand_d     = icand_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;
    out_ch_d    = out_ch_q;
    out_val_d   = out_val_q;
    integ_d     = integ_q;
    prev_d      = prev_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ch_d   = in_ch;
          ref_d  = ref_in;
          meas_d = meas;
          kp_d   = kp;
          ki_d   = ki;
          kd_d   = kd;
          clr_d  = clr;
        end
      end
      S_ERR: begin
        e_d    = EW'(ref_q) - EW'(meas_q);
        iold_d = clr_q ? '0 : integ_q[ch_q];
        pe_d   = clr_q ? '0 : prev_q[ch_q];
      end
      S_PROP: acc_d = AW'(prod);
      S_INTG: begin
        icand_d = icand_c;
        acc_d   = acc_q + AW'(prod);
      end
      S_DERV: acc_d = acc_q + AW'(prod);
      S_OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_val_d   = sat_val;
          out_sat_d   = sat_hi | sat_lo;
          out_ch_d    = ch_q;
        end else if (out_ready) begin
          out_valid_d    = 1'b0;
          prev_d[ch_q]   = e_q;
          integ_d[ch_q]  = wind ? iold_q
                                : icand_q;
        end
      end
      default: ;
    endcase
  end

  // datapath and channel state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q        <= '0;
      ref_q       <= '0;
      meas_q      <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      clr_q       <= 1'b0;
      e_q         <= '0;
      pe_q        <= '0;
      iold_q      <= '0;
      icand_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      out_ch_q    <= '0;
      out_val_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        integ_q[i] <= '0;
        prev_q[i]  <= '0;
      end
    end else begin
      ch_q        <= ch_d;
      ref_q       <= ref_d;
      meas_q      <= meas_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      kd_q        <= kd_d;
      clr_q       <= clr_d;
      e_q         <= e_d;
      pe_q        <= pe_d;
      iold_q      <= iold_d;
      icand_q     <= icand_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      out_ch_q    <= out_ch_d;
      out_val_q   <= out_val_d;
      for (int i = 0; i < NCH; i++) begin
        integ_q[i] <= integ_d[i];
        prev_q[i]  <= prev_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pid_mc_core.sv
// Directed scoreboard bench for the
// multi-channel PID core.
module tb_pid_mc_core;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_ch;
  logic [15:0]       ref_in;
  logic [15:0]       meas;
  logic [15:0]       kp, ki, kd;
  logic              clr;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_ch;
  logic [15:0]       out_val;
  logic              out_sat;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [15:0] val;
    logic        sat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pid_mc_core #(
    .DW  (16),
    .CW  (16),
    .FRAC(8),
    .NCH (4),
    .IW  (24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .ref_in   (ref_in),
    .meas     (meas),
    .kp       (kp),
    .ki       (ki),
    .kd       (kd),
    .clr      (clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_val  (out_val),
    .out_sat  (out_sat)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic [1:0] ch,
    input int r, m, p, i, d,
    input logic c
  );
    in_ch    = ch;
    ref_in   = 16'(r);
    meas     = 16'(m);
    kp       = 16'(p);
    ki       = 16'(i);
    kd       = 16'(d);
    clr      = c;
    in_valid = 1'b1;
  endtask

  task automatic accept(
    input logic [1:0] ch,
    input int r, m, p, i, d,
    input logic c
  );
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(in_ready), 1);
    drive(ch, r, m, p, i, d, c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic push(
    input logic [1:0] ch,
    input int v,
    input logic s
  );
    exp_t e;
    e.ch  = ch;
    e.val = 16'(v);
    e.sat = s;
    sb.push_back(e);
  endtask

  task automatic collect(
    input string tag,
    input bit    latchk
  );
    int   n = 0;
    exp_t e;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (latchk) chk({tag, "_lat"}, 32'(n), 5);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_sb"}, 32'(sb.size()), 1);
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.ch  = '0;
      e.val = '0;
      e.sat = 1'b0;
    end
    chk({tag, "_ch"}, 32'(out_ch), 32'(e.ch));
    chk({tag, "_val"}, 32'(out_val), 32'(e.val));
    chk({tag, "_sat"}, 32'(out_sat), 32'(e.sat));
    if (out_ready) begin
      @(posedge clk);
      #1;
      chk({tag, "_done"}, 32'(out_valid), 0);
    end
  endtask

  task automatic pid(
    input string tag,
    input logic [1:0] ch,
    input int r, m, p, i, d,
    input logic c,
    input int v,
    input logic s
  );
    accept(ch, r, m, p, i, d, c);
    push(ch, v, s);
    collect(tag, 1'b1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_val"}, 32'(out_val), 0);
    chk({tag, "_out_sat"}, 32'(out_sat), 0);
    chk({tag, "_out_ch"}, 32'(out_ch), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_ch     = '0;
    ref_in    = '0;
    meas      = '0;
    kp        = '0;
    ki        = '0;
    kd        = '0;
    clr       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst = 1'b0;

    pid("p_only", 2'd0, 100, 40, 256, 0, 0,
        1'b0, 60, 1'b0);
    pid("no_wrap", 2'd0, 32767, -32768, 1, 0, 0,
        1'b0, 255, 1'b0);

    pid("int1", 2'd1, 50, 40, 0, 256, 0,
        1'b0, 10, 1'b0);
    pid("int2", 2'd1, 50, 40, 0, 256, 0,
        1'b0, 20, 1'b0);
    pid("int3", 2'd1, 50, 40, 0, 256, 0,
        1'b0, 30, 1'b0);

    pid("sat_hi", 2'd2, 1000, 0, 32767, 1, 0,
        1'b0, 32767, 1'b1);
    pid("awu", 2'd2, 10, 0, 0, 256, 0,
        1'b0, 10, 1'b0);
    pid("sat_lo", 2'd3, 0, 1000, 32767, 0, 0,
        1'b0, -32768, 1'b1);
    pid("floor", 2'd3, 0, 1, 1, 0, 0,
        1'b1, -1, 1'b0);

    pid("der_clr", 2'd3, 60, 0, 0, 0, 256,
        1'b1, 60, 1'b0);
    pid("der_0", 2'd3, 60, 0, 0, 0, 256,
        1'b0, 0, 1'b0);

    out_ready = 1'b0;
    accept(2'd1, 5, 0, 256, 0, 0, 1'b0);
    push(2'd1, 5, 1'b0);
    begin
      int n = 0;
      while (!out_valid && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("bp_lat", 32'(n), 5);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 3)
        drive(2'd0, 1000, 0, 256, 0, 0, 1'b0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_val", 32'(out_val), 5);
      chk("bp_ch", 32'(out_ch), 1);
      chk("bp_sat", 32'(out_sat), 0);
      chk("bp_busy", 32'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    collect("bp", 1'b0);
    chk("bp_idle", 32'(in_ready), 1);
    pid("bp_next", 2'd0, 7, 0, 256, 0, 0,
        1'b0, 7, 1'b0);

    accept(2'd1, 10, 0, 0, 256, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_sb", 32'(sb.size()), 0);
    pid("post_rst", 2'd1, 10, 0, 0, 256, 0,
        1'b0, 10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pid_mc_core.md
PID_MC_CORE -- requirements
Module: pid_mc_core

Interface
REQ-001 SHALL have parameter DW, default 16, the signed width of the ref, meas and output samples.
REQ-002 SHALL have parameter CW, default 16, the signed width of the gains.
REQ-003 SHALL have parameter FRAC, default 8, the number of gain fraction bits removed by the output shift.
REQ-004 SHALL have parameter NCH, default 4, the channel count; legal range 1..16.
REQ-005 SHALL have parameter IW, default DW+8, the signed width of the per-channel integrator.
REQ-006 SHALL have ports as follows; the clock is clk and the reset rst is synchronous and active-high; ports are listed name, direction, width, meaning.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  sample offered
- in_ready  out  1  core idle and accepting
- in_ch  in  clog2(NCH)  channel of the sample
- ref  in  DW  setpoint, signed
- meas  in  DW  measurement, signed
- kp, ki, kd  in  CW each  signed gains, sampled at accept
- clr  in  1  with in_valid, zero the channel integrator and previous error before use
- out_valid  out  1  result held until taken
- out_ready  in  1  consumer accepts
- out_ch  out  clog2(NCH)  channel of the result
- out_val  out  DW  saturated control output, signed
- out_sat  out  1  out_val was clipped

Function
REQ-007 SHALL accept a sample only on a cycle where in_valid and in_ready are both high; in_ready SHALL be high only in IDLE.
REQ-008 SHALL run the FSM IDLE -> ERR -> PROP -> INTG -> DERV -> OUT -> IDLE, advancing one state per clock, except OUT, which SHALL hold until out_ready is high.
REQ-009 ERR SHALL compute e = ref - meas at DW+1 bits with no wrap.
REQ-010 PROP SHALL set acc = kp*e.
REQ-011 INTG SHALL form icand = integ[ch] + e, clamp it to the signed IW range, and add ki*icand to acc.
REQ-012 DERV SHALL add kd*(e - prev_e[ch]) to acc, with the difference held at DW+2 bits.
REQ-013 acc SHALL be wide enough that no overflow is possible: CW+IW+3 bits minimum.
REQ-014 On entry to OUT, the core SHALL compute acc >>> FRAC (arithmetic shift, truncation toward minus infinity), clip it to [-2^(DW-1), 2^(DW-1)-1], and set out_sat on any clip.
REQ-015 out_valid SHALL rise exactly 5 cycles after the accept edge when out_ready is held high; out_ch, out_val and out_sat SHALL be stable while out_valid is high.
REQ-016 Writeback SHALL occur on the out_valid and out_ready edge: prev_e[ch] <= e; integ[ch] <= icand, except that integ[ch] SHALL keep its old value when out_sat is set and icand moves further in the same sign as the clip (anti-windup).
REQ-017 clr SHALL make integ[ch] and prev_e[ch] read as 0 for this sample; they are then written back per REQ-016.
REQ-018 Channels SHALL be fully independent; no state is shared except the datapath.
REQ-019 The single multiplier SHALL be time-shared across PROP, INTG and DERV; there SHALL be no more than one multiply per cycle.
REQ-020 in_valid while the core is busy SHALL be ignored, with no effect.
REQ-021 out_ready without out_valid SHALL be ignored.

Reset
REQ-022 rst high at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, out_val=0, out_sat=0, out_ch=0, and all integ[] and prev_e[] to 0.
REQ-023 Reset mid-operation SHALL abandon the sample, with no writeback, and rst SHALL take priority over every input.

Structure
REQ-024 Package pid_pkg SHALL hold the FSM state enum and the width helper constants (error width, difference width, accumulator width).
REQ-025 Sub-module pid_sat SHALL perform the shift, clip and out_sat generation; it is combinational and parametrised by the input width, DW and FRAC.
REQ-026 The per-channel integ[] and prev_e[] SHALL be register arrays indexed by the latched channel.

Verification (DW=16, FRAC=8, NCH=4)
REQ-027 P only: kp=256, ki=kd=0, ch0, ref=100, meas=40 -> out_val=60, out_sat=0, out_valid 5 cycles after accept.
REQ-028 Integral: ki=256, kp=kd=0, three ch1 samples each with e=10 -> out_val 10, 20, 30.
REQ-029 Saturation and anti-windup: kp=32767, e=1000 -> out_val=32767, out_sat=1; with ki>0, integ[ch] stays unchanged.
REQ-030 Derivative with clr: clr=1, kd=256, e=60 -> out 60; next sample with e=60 -> out 0.
REQ-031 Backpressure and busy: with out_ready=0 for 10 cycles, out_valid and outputs stay stable and in_ready=0; a second in_valid is ignored; accept resumes after the handshake.
REQ-032 Reset mid-op: rst asserted in INTG -> all outputs at reset values next cycle, and a subsequent sample on that channel sees integ=0.
